// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed LAT-cycle response: ack arrives LAT+1 cycles after accept.
// One request in flight; req is ignored while busy, so callers hold req until it is accepted.
module data_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write_en,
    input  logic [15:0] addrM,
    input  logic [15:0] write_dataM,
    output logic        ack,
    output logic [15:0] read_dataM,
    output logic        err,
    output logic        busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        oor_q, oor_d;
    logic [15:0] mem_q [DEPTH];

    logic              enter_resp;
    logic              src_we;
    logic [15:0]       src_addr;
    logic [15:0]       src_wdata;
    logic              src_in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        oor_d      = oor_q;
        enter_resp = 1'b0;
        mem_we     = 1'b0;
        src_we     = we_q;
        src_addr   = addr_q;
        src_wdata  = wdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = write_en;
                    addr_d  = addrM;
                    wdata_d = write_dataM;
                    cnt_d   = 4'(LAT);
                    // With no wait the access happens on the accept edge, so use the live inputs.
                    src_we    = write_en;
                    src_addr  = addrM;
                    src_wdata = write_dataM;
                    if (LAT == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        src_in_range = (src_addr >> ADDR_W) == 16'd0;
        mem_idx      = src_addr[ADDR_W-1:0];

        if (enter_resp) begin
            oor_d = !src_in_range;
            if (!src_in_range) begin
                rdata_d = 16'h0000;
            end else if (src_we) begin
                mem_we = 1'b1;
            end else begin
                rdata_d = mem_q[mem_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            oor_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            oor_q   <= oor_d;
            if (mem_we) begin
                mem_q[mem_idx] <= src_wdata;
            end
        end
    end

    assign ack        = (state_q == RESP);
    assign err        = ack & oor_q;
    assign busy       = (state_q != IDLE);
    assign read_dataM = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LAT=2 instance for the main scenarios, LAT=0 instance for the zero-wait case.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset;

    logic        req, write_en;
    logic [15:0] addrM, write_dataM;
    logic        ack, err, busy;
    logic [15:0] read_dataM;

    logic        req0, write_en0;
    logic [15:0] addrM0, write_dataM0;
    logic        ack0, err0, busy0;
    logic [15:0] read_dataM0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(8), .LAT(2)) dut (
        .clk(clk), .reset(reset), .req(req), .write_en(write_en),
        .addrM(addrM), .write_dataM(write_dataM),
        .ack(ack), .read_dataM(read_dataM), .err(err), .busy(busy)
    );

    data_mem_responder #(.ADDR_W(8), .LAT(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .write_en(write_en0),
        .addrM(addrM0), .write_dataM(write_dataM0),
        .ack(ack0), .read_dataM(read_dataM0), .err(err0), .busy(busy0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request on the LAT=2 instance and captures the ack cycle and response fields.
    task automatic issue(input logic we, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd, output logic e);
        lat = -1;
        rd  = 16'hxxxx;
        e   = 1'bx;
        req = 1'b1; write_en = we; addrM = a; write_dataM = d;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) req = 1'b0;
            if (ack === 1'b1) begin
                lat = k;
                rd  = read_dataM;
                e   = err;
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b1; write_en = 1'b0; addrM = 16'h0005; write_dataM = 16'h0;
        req0 = 1'b1; write_en0 = 1'b0; addrM0 = 16'h0; write_dataM0 = 16'h0;
        step(); step();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (read_dataM !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h exp 0000", read_dataM); end
        reset = 1'b0; req = 1'b0; req0 = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_req_discard busy got %b exp 0", busy); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_req_discard0 busy got %b exp 0", busy0); end
    endtask

    task automatic test_read_after_reset();
        int lat; logic [15:0] rd; logic e;
        issue(1'b0, 16'h0005, 16'h0, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd5_latency got %0d exp 3", lat); end
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rd5_data got %h exp 0000", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd5_err got %b exp 0", e); end
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] rd; logic e;
        issue(1'b1, 16'h0012, 16'hBEEF, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr12_latency got %0d exp 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr12_err got %b exp 0", e); end
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL wr12_rdata_held got %h exp 0000", rd); end
        issue(1'b0, 16'h0012, 16'h0, lat, rd, e);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd12_data got %h exp beef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd12_err got %b exp 0", e); end
        issue(1'b1, 16'h0013, 16'h5555, lat, rd, e);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL wr13_rdata_held got %h exp beef", rd); end
        issue(1'b0, 16'h0013, 16'h0, lat, rd, e);
        checks++; if (rd !== 16'h5555) begin errors++; $display("FAIL rd13_data got %h exp 5555", rd); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] rd; logic e;
        issue(1'b1, 16'h0112, 16'h1234, lat, rd, e);
        checks++; if (lat !== 3) begin errors++; $display("FAIL oorwr_latency got %0d exp 3", lat); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oorwr_err got %b exp 1", e); end
        issue(1'b0, 16'h0012, 16'h0, lat, rd, e);
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL oorwr_nowrite got %h exp beef", rd); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL oorwr_followup_err got %b exp 0", e); end
        issue(1'b0, 16'h0112, 16'h0, lat, rd, e);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL oorrd_data got %h exp 0000", rd); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oorrd_err got %b exp 1", e); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_after_ack got %b exp 0", err); end
    endtask

    task automatic test_back_to_back();
        logic exp_ack, exp_busy;
        req = 1'b1; write_en = 1'b0; addrM = 16'h0012; write_dataM = 16'h0;
        for (int c = 0; c < 12; c++) begin
            exp_ack  = (c == 3) || (c == 7) || (c == 11);
            exp_busy = (c % 4) != 0;
            checks++; if (ack !== exp_ack) begin errors++; $display("FAIL b2b_ack cyc %0d got %b exp %b", c, ack, exp_ack); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy cyc %0d got %b exp %b", c, busy, exp_busy); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err cyc %0d got %b exp 0", c, err); end
            step();
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd; logic e;
        req = 1'b1; write_en = 1'b1; addrM = 16'h0020; write_dataM = 16'hAAAA;
        step();
        req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack got %b exp 0", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        step();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack_late got %b exp 0", ack); end
        issue(1'b0, 16'h0020, 16'h0, lat, rd, e);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rstmid_rd20 got %h exp 0000", rd); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL rstmid_rd20_latency got %0d exp 3", lat); end
        issue(1'b0, 16'h0012, 16'h0, lat, rd, e);
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL rstmid_array_clear got %h exp 0000", rd); end
    endtask

    task automatic test_lat0();
        logic exp_ack;
        req0 = 1'b1; write_en0 = 1'b1; addrM0 = 16'h0030; write_dataM0 = 16'h4321;
        for (int c = 0; c < 6; c++) begin
            exp_ack = (c % 2) == 1;
            checks++; if (ack0 !== exp_ack) begin errors++; $display("FAIL lat0_ack cyc %0d got %b exp %b", c, ack0, exp_ack); end
            checks++; if (busy0 !== exp_ack) begin errors++; $display("FAIL lat0_busy cyc %0d got %b exp %b", c, busy0, exp_ack); end
            if (c == 3) begin
                checks++; if (read_dataM0 !== 16'h4321) begin errors++; $display("FAIL lat0_rd got %h exp 4321", read_dataM0); end
            end
            if (c == 1) begin
                write_en0 = 1'b0;
            end
            step();
        end
        req0 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        test_lat0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the storage array (2^ADDR_W 16-bit words).
REQ-002 SHALL have parameter LAT, default 2, wait cycles between request acceptance and response (legal 0..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req  input  1  request strobe from the memory stage; sampled only in IDLE.
REQ-007 write_en  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addrM  input  16  word address; sampled with req.
REQ-009 write_dataM  input  16  write data; sampled with req.
REQ-010 ack  output  1  one-cycle response pulse; completes the accepted request.
REQ-011 read_dataM  output  16  read result; valid while ack=1 for a read.
REQ-012 err  output  1  out-of-range flag; valid while ack=1.
REQ-013 busy  output  1  1 whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; all outputs registered or decoded from state only, with no combinational path from inputs to outputs.
REQ-015 IDLE + req=1 at edge E: SHALL latch write_en, addrM, write_dataM; load wait counter with LAT; go to WAIT if LAT>0, else RESP.
REQ-016 IDLE + req=0: SHALL remain in IDLE; no storage or output change.
REQ-017 WAIT: SHALL decrement the counter each cycle; on the edge where counter=1, go to RESP.
REQ-018 Latency: req sampled in cycle 0 SHALL yield ack=1 in exactly cycle LAT+1 and in no other cycle.
REQ-019 RESP: ack=1 for exactly one cycle, then unconditionally IDLE; req is ignored in RESP and WAIT (no queueing, no error).
REQ-020 Throughput: next request accepted no earlier than the cycle after ack, i.e. one request per LAT+2 cycles maximum.
REQ-021 Range check: latched addrM[15:ADDR_W] nonzero SHALL make err=1 during ack; write suppressed; read_dataM=16'h0000 for that response.
REQ-022 In-range write: array[addr[ADDR_W-1:0]] SHALL be updated on the edge entering RESP; read_dataM unchanged.
REQ-023 In-range read: read_dataM SHALL load array[addr] on the edge entering RESP; read_dataM holds that value until the next read response or reset.
REQ-024 Read-after-write: a read accepted after a write's ack SHALL return the written data.
REQ-025 err SHALL be 0 whenever ack=0.
REQ-026 busy SHALL be 1 from the cycle after acceptance through the ack cycle inclusive.

Reset
REQ-027 reset=1 at any edge, including mid-WAIT or RESP, SHALL force IDLE, counter=0, ack=0, err=0, busy=0, read_dataM=16'h0000, and abort any pending request without writing.
REQ-028 reset SHALL clear every array word to 16'h0000.
REQ-029 req asserted in the same cycle as reset SHALL be discarded.

Verification (ADDR_W=8, LAT=2)
REQ-030 Reset, then read addr 0x0005 -> ack exactly 3 cycles after req, read_dataM=0x0000, err=0.
REQ-031 Write 0xBEEF to 0x0012, then read 0x0012 after its ack -> read_dataM=0xBEEF, err=0; read_dataM unchanged during the write ack.
REQ-032 Write 0x1234 to 0x0112 -> ack with err=1; subsequent read of 0x0012 returns the prior value (0xBEEF); out-of-range read returns 0x0000 with err=1.
REQ-033 req held high continuously for 12 cycles -> ack pulses at cycles 3, 7, 11 only; busy low only on accept cycles.
REQ-034 Write 0xAAAA to 0x0020, reset asserted in the cycle before ack -> no ack; read of 0x0020 after reset returns 0x0000.
REQ-035 Rebuild with LAT=0 -> ack in the cycle immediately after req; back-to-back requests accepted every 2 cycles.
